// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion sequencer.
// The latency helper gives the start-to-valid cycle count for a configuration.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4,
    WAIT    = 3'd5
  } sar_state_e;

  localparam int SAR_NBITS         = 10;
  localparam int SAR_SAMPLE_CYCLES = 4;
  localparam int SAR_SETTLE_CYCLES = 2;
  localparam int SAR_SYNC_STAGES   = 2;
  localparam int SAR_INTERVAL_W    = 16;

  // Cycle index of valid_o when start_i is high in cycle 0.
  function automatic int unsigned conv_latency(input int unsigned nbits,
                                               input int unsigned sample_cycles,
                                               input int unsigned settle_cycles);
    return 1 + sample_cycles + nbits * (settle_cycles + 1);
  endfunction

endpackage

// File: rtl/sar_comp_sync.sv
// Multi-flop synchronizer bringing the asynchronous comparator output into
// the wb_clk_i domain.
module sar_comp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: track/hold strobe, MSB-first binary search on
// the DAC code, and a ready/read result handshake with sticky overrun.
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int NBITS         = SAR_NBITS,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = SAR_SYNC_STAGES,
  parameter int INTERVAL_W    = SAR_INTERVAL_W
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  cont_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic                  comp_in,
  input  logic                  rd_i,
  input  logic                  clr_ovr_i,
  output logic                  sample_o,
  output logic [NBITS-1:0]      dac_code_o,
  output logic                  busy_o,
  output logic [NBITS-1:0]      result_o,
  output logic                  valid_o,
  output logic                  data_ready_o,
  output logic                  overrun_o
);

  localparam int PHASE_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int PH_W      = $clog2(PHASE_MAX + 1);
  localparam int BIT_W     = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [PH_W-1:0]  SAMPLE_LOAD = PH_W'(SAMPLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LOAD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_ONE     = {1'b1, {(NBITS-1){1'b0}}};

  // The comparator must be fully synchronized before the compare cycle samples it.
  if (SETTLE_CYCLES < SYNC_STAGES) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= SYNC_STAGES");
  end
  if (NBITS < 2 || NBITS > 16) begin : g_bad_nbits
    $error("NBITS must be within 2..16");
  end
  if (SAMPLE_CYCLES < 1) begin : g_bad_sample
    $error("SAMPLE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  sar_state_e            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [INTERVAL_W-1:0] gap_q, gap_d;
  logic [NBITS-1:0]      dac_q, dac_d;
  logic [NBITS-1:0]      result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  ovr_q, ovr_d;

  logic                  comp_sync;
  logic [NBITS-1:0]      bit_mask;
  logic [NBITS-1:0]      resolved_code;

  sar_comp_sync #(
    .STAGES(SYNC_STAGES)
  ) u_comp_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d_i(comp_in),
    .q_o(comp_sync)
  );

  assign bit_mask      = NBITS'(1) << bit_q;
  assign resolved_code = comp_sync ? dac_q : (dac_q & ~bit_mask);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    dac_d    = dac_q;
    result_d = result_q;
    ready_d  = ready_q & ~rd_i;
    ovr_d    = ovr_q & ~clr_ovr_i;

    case (state_q)
      IDLE: begin
        if (start_i || cont_i) begin
          state_d = SAMPLE;
          phase_d = SAMPLE_LOAD;
          dac_d   = '0;
        end
      end
      SAMPLE: begin
        if (phase_q == '0) begin
          state_d = SETTLE;
          phase_d = SETTLE_LOAD;
          bit_d   = MSB_IDX;
          dac_d   = MSB_ONE;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      SETTLE: begin
        if (phase_q == '0) begin
          state_d = COMPARE;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      COMPARE: begin
        // Resolve the current bit and present the next trial in the same edge.
        if (bit_q == '0) begin
          state_d  = DONE;
          dac_d    = resolved_code;
          result_d = resolved_code;
        end else begin
          state_d = SETTLE;
          phase_d = SETTLE_LOAD;
          bit_d   = bit_q - 1'b1;
          dac_d   = resolved_code | (bit_mask >> 1);
        end
      end
      DONE: begin
        ready_d = 1'b1;
        if (ready_q && !rd_i) begin
          ovr_d = 1'b1;
        end
        if (!cont_i) begin
          state_d = IDLE;
        end else if (interval_i != '0) begin
          state_d = WAIT;
          gap_d   = interval_i;
        end else begin
          state_d = SAMPLE;
          phase_d = SAMPLE_LOAD;
          dac_d   = '0;
        end
      end
      WAIT: begin
        // Gap counter runs from the latched interval down to zero inclusive.
        if (!cont_i) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          state_d = SAMPLE;
          phase_d = SAMPLE_LOAD;
          dac_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_o     = (state_q == SAMPLE);
  assign busy_o       = (state_q != IDLE);
  assign valid_o      = (state_q == DONE);
  assign dac_code_o   = dac_q;
  assign result_o     = result_q;
  assign data_ready_o = ready_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Self-checking bench for sar_conv_sequencer with a behavioural comparator
// and a scoreboard of expected conversion results.
module tb_sar_conv_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        cont_i = 1'b0;
  logic [15:0] interval_i = '0;
  logic        comp_in;
  logic        rd_i = 1'b0;
  logic        clr_ovr_i = 1'b0;
  logic        sample_o;
  logic [9:0]  dac_code_o;
  logic        busy_o;
  logic [9:0]  result_o;
  logic        valid_o;
  logic        data_ready_o;
  logic        overrun_o;

  // comparator model: mode 0 compares against vin, 1 stuck high, 2 stuck low
  logic [9:0]  vin = '0;
  int          compMode = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int validCnt = 0;
  int validCyc = 0;
  int startCyc = 0;
  logic [9:0] expQ[$];

  sar_conv_sequencer dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .start_i     (start_i),
    .cont_i      (cont_i),
    .interval_i  (interval_i),
    .comp_in     (comp_in),
    .rd_i        (rd_i),
    .clr_ovr_i   (clr_ovr_i),
    .sample_o    (sample_o),
    .dac_code_o  (dac_code_o),
    .busy_o      (busy_o),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .data_ready_o(data_ready_o),
    .overrun_o   (overrun_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  always_comb begin
    case (compMode)
      1:       comp_in = 1'b1;
      2:       comp_in = 1'b0;
      default: comp_in = (dac_code_o <= vin);
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard consumer: every valid_o pulse pops one expected result.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && valid_o) begin
      validCnt++;
      validCyc = cyc;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 32'(result_o), 32'hFFFF_FFFF);
      end else begin
        checkOutput("result", 32'(result_o), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [9:0] v, input int mode, input logic useCont,
                               input int nExpected);
    logic [9:0] expVal;
    @(negedge wb_clk_i);
    vin = v;
    compMode = mode;
    expVal = (mode == 1) ? 10'h3FF : (mode == 2) ? 10'h000 : v;
    for (int i = 0; i < nExpected; i++) expQ.push_back(expVal);
    startCyc = cyc;
    if (useCont) begin
      cont_i = 1'b1;
    end else begin
      start_i = 1'b1;
      @(negedge wb_clk_i);
      start_i = 1'b0;
    end
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) @(negedge wb_clk_i);
  endtask

  task automatic waitValid(input int target);
    for (int i = 0; i < 300 && validCnt < target; i++) @(negedge wb_clk_i);
    if (validCnt < target) checkOutput("valid_timeout", 32'(validCnt), 32'(target));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_o), 0);
    checkOutput({tag, "_sample"}, 32'(sample_o), 0);
    checkOutput({tag, "_dac"}, 32'(dac_code_o), 0);
    checkOutput({tag, "_result"}, 32'(result_o), 0);
    checkOutput({tag, "_valid"}, 32'(valid_o), 0);
    checkOutput({tag, "_ready"}, 32'(data_ready_o), 0);
    checkOutput({tag, "_ovr"}, 32'(overrun_o), 0);
  endtask

  initial begin
    int v1;
    int cntBefore;
    logic [9:0] trial;

    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    checkAllZero("reset");

    // single shot, Vin = 0x2A5, plus an ignored start_i while busy
    applyStimulus(10'h2A5, 0, 1'b0, 1);
    waitCycle(startCyc + 10);
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    waitValid(1);
    checkOutput("latency_a", 32'(validCyc - startCyc), 35);
    waitCycle(validCyc + 1);
    checkOutput("ready_a", 32'(data_ready_o), 1);
    checkOutput("ovr_a", 32'(overrun_o), 0);
    checkOutput("idle_after_a", 32'(busy_o), 0);
    checkOutput("dac_hold_a", 32'(dac_code_o), 32'h2A5);
    waitCycle(validCyc + 40);
    checkOutput("single_valid_a", 32'(validCnt), 1);

    // comparator stuck high: trace the trial codes 0x200, 0x300, ...
    applyStimulus(10'h000, 1, 1'b0, 1);
    waitCycle(startCyc + 2);
    checkOutput("sample_b", 32'(sample_o), 1);
    checkOutput("dac_in_sample_b", 32'(dac_code_o), 0);
    for (int k = 0; k < 10; k++) begin
      waitCycle(startCyc + 5 + 3 * k);
      trial = 10'h3FF >> (k + 1);
      trial = ~trial;
      checkOutput($sformatf("trial_b%0d", k), 32'(dac_code_o), 32'(trial));
    end
    waitValid(2);
    checkOutput("latency_b", 32'(validCyc - startCyc), 35);

    // comparator stuck low
    applyStimulus(10'h3FF, 2, 1'b0, 1);
    waitValid(3);
    waitCycle(validCyc + 1);
    checkOutput("ovr_after_unread", 32'(overrun_o), 1);

    // clear status, then continuous mode with interval 5 and no reads
    @(negedge wb_clk_i);
    rd_i = 1'b1;
    clr_ovr_i = 1'b1;
    @(negedge wb_clk_i);
    rd_i = 1'b0;
    clr_ovr_i = 1'b0;
    checkOutput("ready_cleared", 32'(data_ready_o), 0);
    checkOutput("ovr_cleared", 32'(overrun_o), 0);
    interval_i = 16'd5;
    applyStimulus(10'h155, 0, 1'b1, 2);
    waitValid(4);
    v1 = validCyc;
    checkOutput("latency_c", 32'(v1 - startCyc), 35);
    waitCycle(v1 + 1);
    checkOutput("ovr_c1", 32'(overrun_o), 0);
    checkOutput("wait_busy_c", 32'(busy_o), 1);
    waitValid(5);
    checkOutput("cont_period", 32'(validCyc - v1), 41);
    waitCycle(validCyc + 1);
    checkOutput("ovr_c2", 32'(overrun_o), 1);
    clr_ovr_i = 1'b1;
    waitCycle(validCyc + 2);
    clr_ovr_i = 1'b0;
    checkOutput("ovr_clr_c", 32'(overrun_o), 0);
    cont_i = 1'b0;
    waitCycle(validCyc + 3);
    checkOutput("wait_drop_busy", 32'(busy_o), 0);
    checkOutput("wait_drop_ready", 32'(data_ready_o), 1);

    // read on the DONE cycle while a result is still unread
    applyStimulus(10'h3C3, 0, 1'b0, 1);
    waitCycle(startCyc + 35);
    rd_i = 1'b1;
    waitCycle(startCyc + 36);
    rd_i = 1'b0;
    checkOutput("valid_d", 32'(validCnt), 6);
    checkOutput("ready_d", 32'(data_ready_o), 1);
    checkOutput("ovr_d", 32'(overrun_o), 0);

    // reset in cycle 12 of a conversion aborts it
    applyStimulus(10'h1E7, 0, 1'b0, 1);
    waitCycle(startCyc + 12);
    wb_rst_i = 1'b1;
    expQ.delete();
    cntBefore = validCnt;
    waitCycle(startCyc + 13);
    wb_rst_i = 1'b0;
    checkAllZero("abort");
    waitCycle(startCyc + 60);
    checkOutput("no_valid_after_abort", 32'(validCnt), 32'(cntBefore));
    applyStimulus(10'h0F0, 0, 1'b0, 1);
    waitValid(cntBefore + 1);
    checkOutput("latency_e", 32'(validCyc - startCyc), 35);
    waitCycle(validCyc + 1);
    checkOutput("ready_e", 32'(data_ready_o), 1);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
